// File: rtl/mcht_pkg.sv
// Shared types and constants for the Manchester transceiver host-side stages.
package mcht_pkg;

  localparam int MSG_LEN = 8;

  typedef logic [MSG_LEN-1:0] mcht_msg_t;

  typedef logic [1:0] mcht_state_t;

  localparam mcht_state_t ST_IDLE = 2'd0;
  localparam mcht_state_t ST_SEND = 2'd1;
  localparam mcht_state_t ST_WAIT = 2'd2;
  localparam mcht_state_t ST_GAP  = 2'd3;

endpackage

// File: rtl/mcht_sync_fifo.sv
// Small synchronous FIFO with occupancy count; shared by the tx feeder and rx buffer.
module mcht_sync_fifo
  import mcht_pkg::*;
#(
  parameter int WIDTH = MSG_LEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/mcht_tx_feeder.sv
// Buffers host messages and issues them one frame at a time to the Manchester transmitter,
// with an inter-frame gap, a halt input and a lost-TX_DNE timeout.
module mcht_tx_feeder
  import mcht_pkg::*;
#(
  parameter int pMSG_LEN = MSG_LEN,
  parameter int pDEPTH   = 4,
  parameter int pGAP     = 2,
  parameter int pTMO     = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      halt,
  input  logic                      in_vld,
  input  logic [pMSG_LEN-1:0]       in_msg,
  output logic                      in_rdy,
  output logic                      tx_vld,
  output logic [pMSG_LEN-1:0]       tx_msg,
  input  logic                      tx_dne,
  output logic [$clog2(pDEPTH):0]   level,
  output logic                      busy,
  output logic [7:0]                frm_cnt,
  output logic                      tmo_err,
  input  logic                      clr_err
);

  localparam int TW = $clog2(pTMO + 1);
  localparam int GW = $clog2(pGAP + 1);

  mcht_state_t         state_q, state_d;
  logic                tx_vld_q, tx_vld_d;
  logic [pMSG_LEN-1:0] tx_msg_q, tx_msg_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [7:0]          frm_cnt_q, frm_cnt_d;
  logic                tmo_err_q, tmo_err_d;
  logic                tmo_set;
  logic                start;
  logic                fifo_full, fifo_empty;
  logic [pMSG_LEN-1:0] fifo_dout;

  mcht_sync_fifo #(
    .WIDTH (pMSG_LEN),
    .DEPTH (pDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_vld & ~fifo_full),
    .pop   (start),
    .din   (in_msg),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign start = (state_q == ST_IDLE) & ~fifo_empty & ~halt;

  // tx_dne is checked before the timeout so a completion on the last WAIT cycle still counts.
  always_comb begin
    state_d   = state_q;
    tx_vld_d  = 1'b0;
    tx_msg_d  = tx_msg_q;
    tmo_cnt_d = tmo_cnt_q;
    gap_cnt_d = gap_cnt_q;
    frm_cnt_d = frm_cnt_q;
    tmo_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SEND;
          tx_vld_d = 1'b1;
          tx_msg_d = fifo_dout;
        end
      end
      ST_SEND: begin
        state_d   = ST_WAIT;
        tmo_cnt_d = '0;
      end
      ST_WAIT: begin
        if (tx_dne) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          frm_cnt_d = frm_cnt_q + 8'd1;
        end else if (tmo_cnt_q == TW'(pTMO - 1)) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          tmo_set   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(pGAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tmo_err_d = tmo_set | (tmo_err_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_vld_q  <= 1'b0;
      tx_msg_q  <= '0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
      frm_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_vld_q  <= tx_vld_d;
      tx_msg_q  <= tx_msg_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign in_rdy  = ~fifo_full;
  assign tx_vld  = tx_vld_q;
  assign tx_msg  = tx_msg_q;
  assign busy    = (state_q != ST_IDLE);
  assign frm_cnt = frm_cnt_q;
  assign tmo_err = tmo_err_q;

endmodule
